// File: rtl/arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Holds state/owner encodings and the fixed fetch attributes.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  localparam int unsigned STARVE_MAX_DEF = 4;

  // Fetches are always full-word reads.
  localparam logic [3:0] MEM_BE_ALL = 4'hF;
  localparam logic       WE_READ    = 1'b0;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of data grants taken while a fetch was waiting.
// Only instantiated when ARB_STARVE_GUARD_EN is defined.
module arb_starve_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_max
);

  localparam logic [3:0] MAX_L = 4'(MAX);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_inc && (r_cnt != MAX_L)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_at_max = (r_cnt == MAX_L);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch, data) arbiter onto a single-outstanding memory port.
// Define ARB_STARVE_GUARD_EN to let a waiting fetch win after STARVE_MAX data grants.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        fetch_stall
);

  arb_state_t r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_we;
  logic        r_flush;
  logic        r_if_rvalid;
  logic        r_d_rvalid;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  logic       w_idle;
  logic       w_pick_if;
  logic       w_flush_now;
  arb_owner_t w_owner;

`ifdef ARB_STARVE_GUARD_EN
  logic w_at_max;

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (if_gnt),
    .i_inc    (d_gnt & if_req),
    .o_at_max (w_at_max)
  );
`endif

  // Grants are forced low while reset is asserted, not just after the next edge.
  assign w_idle = (r_state == IDLE) && rst_n;

  always_comb begin
    w_pick_if = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    w_pick_if = if_req & (~d_req | w_at_max);
`else
    w_pick_if = if_req & ~d_req;
`endif
  end

  assign if_gnt = w_idle & w_pick_if;
  assign d_gnt  = w_idle & d_req & ~w_pick_if;

  assign w_owner     = (r_state == BUSY_D) ? OWN_D : OWN_IF;
  assign w_flush_now = if_flush | r_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      r_we        <= 1'b0;
      r_flush     <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= 32'd0;
      r_d_rdata   <= 32'd0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (if_gnt) begin
            r_addr  <= if_addr;
            r_we    <= WE_READ;
            r_be    <= MEM_BE_ALL;
            r_wdata <= 32'd0;
            r_flush <= 1'b0;
            r_state <= BUSY_IF;
          end else if (d_gnt) begin
            r_addr  <= d_addr;
            r_we    <= d_we;
            r_be    <= d_be;
            r_wdata <= d_wdata;
            r_flush <= 1'b0;
            r_state <= BUSY_D;
          end
        end
        BUSY_IF, BUSY_D: begin
          if (r_state == BUSY_IF && if_flush) begin
            r_flush <= 1'b1;
          end
          if (mem_ready) begin
            r_state <= IDLE;
            if (w_owner == OWN_D) begin
              r_d_rdata  <= mem_rdata;
              r_d_rvalid <= 1'b1;
            end else if (!w_flush_now) begin
              // A flushed fetch completes on the bus but leaves if_rdata untouched.
              r_if_rdata  <= mem_rdata;
              r_if_rvalid <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req   = (r_state != IDLE);
  assign mem_we    = r_we;
  assign mem_be    = r_be;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;

  assign fetch_stall = if_req & ~r_if_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expectations are hand-derived per cycle.
// Starvation expectations follow whether ARB_STARVE_GUARD_EN is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        fetch_stall;

  int n_total = 0;
  int n_bad   = 0;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_flush    (if_flush),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_be        (d_be),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .fetch_stall (fetch_stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Both requesters held high with a zero-wait memory: a grant every other cycle.
  task automatic run_tie(input int ncyc, input string tag);
    logic exp_if;
    for (int c = 0; c < ncyc; c++) begin
      cyc();
      if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; mem_ready = 1'b1;
      #1;
      if (c % 2 == 0) begin
        exp_if = GUARD && ((c / 2) % 5 == 4);
        chk({tag, "_if_gnt"}, {31'd0, if_gnt}, {31'd0, exp_if});
        chk({tag, "_d_gnt"},  {31'd0, d_gnt},  {31'd0, ~exp_if});
      end else begin
        chk({tag, "_busy"}, {30'd0, if_gnt, d_gnt}, 32'd0);
      end
    end
    cyc();
    if_req = 1'b0; d_req = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if_req = 0; if_addr = 0; if_flush = 0;
    d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    #12;
    chk("rst_mem_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_gnts",      {30'd0, if_gnt, d_gnt}, 32'd0);
    chk("rst_rvalids",   {30'd0, if_rvalid, d_rvalid}, 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'd0);
    chk("rst_if_rdata",  if_rdata, 32'd0);
    cyc();
    rst_n = 1'b1;

    // Single fetch, grant in the first cycle after reset release.
    cyc();
    if_req = 1; if_addr = 32'h100; mem_ready = 1; mem_rdata = 32'h13;
    #1;
    chk("f1_if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("f1_d_gnt",  {31'd0, d_gnt}, 32'd0);
    chk("f1_stall0", {31'd0, fetch_stall}, 32'd1);
    chk("f1_mreq0",  {31'd0, mem_req}, 32'd0);
    cyc(); #1;
    chk("f1_mreq1",  {31'd0, mem_req}, 32'd1);
    chk("f1_maddr",  mem_addr, 32'h100);
    chk("f1_mwe_be", {27'd0, mem_we, mem_be}, 32'h0F);
    chk("f1_stall1", {31'd0, fetch_stall}, 32'd1);
    chk("f1_no_gnt", {31'd0, if_gnt}, 32'd0);
    cyc();
    if_req = 0;
    #1;
    chk("f1_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("f1_rdata",  if_rdata, 32'h13);
    chk("f1_mreq2",  {31'd0, mem_req}, 32'd0);
    cyc(); #1;
    chk("f1_rv_pulse", {31'd0, if_rvalid}, 32'd0);
    chk("f1_rd_hold",  if_rdata, 32'h13);

    // Tie: data wins, three wait states, then the pending fetch is granted.
    cyc();
    if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 1; d_addr = 32'h2000;
    d_be = 4'b0011; d_wdata = 32'hDEADBEEF; mem_ready = 0; mem_rdata = 32'h55AA;
    #1;
    chk("t_d_gnt",  {31'd0, d_gnt}, 32'd1);
    chk("t_if_gnt", {31'd0, if_gnt}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      d_req = 0; d_addr = 32'hFFFF0000 + i; d_be = 4'hC; d_wdata = 32'h0;
      mem_ready = (i == 3);
      #1;
      chk("t_mreq",   {31'd0, mem_req}, 32'd1);
      chk("t_maddr",  mem_addr, 32'h2000);
      chk("t_mwe_be", {27'd0, mem_we, mem_be}, 32'h13);
      chk("t_mwdata", mem_wdata, 32'hDEADBEEF);
      chk("t_hold_if", {31'd0, if_gnt}, 32'd0);
    end
    cyc();
    mem_rdata = 32'h77;
    #1;
    chk("t_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("t_d_rdata",  d_rdata, 32'h55AA);
    chk("t_if_gnt2",  {31'd0, if_gnt}, 32'd1);
    cyc(); #1;
    chk("t_if_maddr", mem_addr, 32'h200);
    chk("t_if_we_be", {27'd0, mem_we, mem_be}, 32'h0F);
    chk("t_d_rv_pulse", {31'd0, d_rvalid}, 32'd0);
    cyc();
    if_req = 0;
    #1;
    chk("t_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("t_if_rdata",  if_rdata, 32'h77);

    // Flush while waiting, then completion: no if_rvalid, data kept.
    cyc();
    if_req = 1; if_addr = 32'h300; mem_ready = 0; mem_rdata = 32'h99;
    #1;
    chk("fl_gnt", {31'd0, if_gnt}, 32'd1);
    cyc();
    if_req = 0; if_flush = 1;
    #1;
    chk("fl_mreq", {31'd0, mem_req}, 32'd1);
    chk("fl_maddr", mem_addr, 32'h300);
    cyc();
    if_flush = 0; mem_ready = 1;
    #1;
    chk("fl_mreq2", {31'd0, mem_req}, 32'd1);
    cyc();
    // Flush during the IDLE grant cycle must not affect the new fetch.
    if_req = 1; if_addr = 32'h400; if_flush = 1; mem_rdata = 32'hAB;
    #1;
    chk("fl_no_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("fl_rd_hold",   if_rdata, 32'h77);
    chk("fl_idle",      {31'd0, mem_req}, 32'd0);
    chk("fl_next_gnt",  {31'd0, if_gnt}, 32'd1);
    cyc();
    if_req = 0; if_flush = 0;
    #1;
    chk("fl_next_addr", mem_addr, 32'h400);
    cyc(); #1;
    chk("fl_next_rv", {31'd0, if_rvalid}, 32'd1);
    chk("fl_next_rd", if_rdata, 32'hAB);

    // Flush in the same cycle the fetch completes.
    cyc();
    if_req = 1; if_addr = 32'h500;
    #1;
    chk("fs_gnt", {31'd0, if_gnt}, 32'd1);
    cyc();
    if_req = 0; if_flush = 1; mem_ready = 1; mem_rdata = 32'hCC;
    #1;
    cyc();
    if_flush = 0;
    #1;
    chk("fs_no_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("fs_rd_hold",   if_rdata, 32'hAB);
    chk("fs_idle",      {31'd0, mem_req}, 32'd0);

    // Continuous tie: 4 data then 1 fetch when guarded, data-only otherwise.
    run_tie(20, "sv");

    // Reset in BUSY_D after one starving data grant.
    cyc();
    if_req = 1; d_req = 1; d_we = 0; d_addr = 32'h3000; mem_ready = 0; mem_rdata = 32'h1234;
    #1;
    chk("rm_d_gnt", {31'd0, d_gnt}, 32'd1);
    cyc();
    if_req = 0;
    #1;
    chk("rm_mreq", {31'd0, mem_req}, 32'd1);
    rst_n = 0;
    #1;
    chk("rm_mreq_async", {31'd0, mem_req}, 32'd0);
    chk("rm_gnt_in_rst", {31'd0, d_gnt}, 32'd0);
    chk("rm_d_rdata",    d_rdata, 32'd0);
    chk("rm_if_rdata",   if_rdata, 32'd0);
    d_req = 0; mem_ready = 1;
    cyc();
    cyc();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("rm_no_rvalid", {30'd0, d_rvalid, if_rvalid}, 32'd0);
      chk("rm_no_mreq",   {31'd0, mem_req}, 32'd0);
    end
    // A stale counter value would let the fetch in before the 5th grant.
    run_tie(10, "sr");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, number of consecutive data grants after which a pending fetch wins (range 1..15).
REQ-002 Reset is rst_n, asynchronous, active-low; the clock is clk.
REQ-003 Ports: clk in 1 clock; rst_n in 1 async active-low reset.
REQ-004 Fetch requester: if_req in 1; if_addr in 32; if_flush in 1 (drop in-flight fetch); if_gnt out 1; if_rvalid out 1; if_rdata out 32.
REQ-005 Data requester: d_req in 1; d_we in 1; d_be in 4; d_addr in 32; d_wdata in 32; d_gnt out 1; d_rvalid out 1; d_rdata out 32.
REQ-006 Memory port: mem_req out 1; mem_we out 1; mem_be out 4; mem_addr out 32; mem_wdata out 32; mem_ready in 1; mem_rdata in 32.
REQ-007 Fetch control: fetch_stall out 1, which drives the fetch stage stall input.

Function
REQ-008 States: IDLE, BUSY_IF, BUSY_D; the arbiter holds at most one outstanding transaction.
REQ-009 Arbitration in IDLE:
- If only one request is present, that requester wins.
- If both are present, data wins, except as stated in REQ-017.
- If neither is present, the arbiter stays in IDLE.
REQ-010 Grant:
- The grant is a combinational one-cycle pulse, if_gnt or d_gnt, in the IDLE accept cycle.
- The granted address, we, be and wdata are registered at the same clock edge.
- The state moves to BUSY_IF or BUSY_D at that edge.
- if_gnt and d_gnt are never high together.
REQ-011 In BUSY_x:
- mem_req = 1.
- The mem_* outputs come from the registered fields only and stay stable until mem_ready.
- For fetches, mem_we = 0 and mem_be = 4'hF.
REQ-012 Completion: on mem_ready = 1 in BUSY_x, mem_rdata is registered and the owner's rvalid pulses for exactly one cycle on the next cycle; the state returns to IDLE.
REQ-013 Latency:
- Minimum grant-to-rvalid latency is 2 cycles (grant, BUSY with ready, rvalid).
- A new grant cannot occur before the rvalid cycle.
- In IDLE during the rvalid cycle, a new request is grant-eligible in that same cycle.
REQ-014 Data writes also pulse d_rvalid as a completion acknowledge; d_rdata is then don't-care but still registered.
REQ-015 if_flush:
- Asserted in BUSY_IF, or in the same cycle as fetch completion, it suppresses the resulting if_rvalid.
- The memory transaction still completes.
- A flush in IDLE has no effect.
REQ-016 fetch_stall = if_req & ~if_rvalid (combinational).
REQ-017 Starvation counter:
- Counts data grants made while if_req = 1, and saturates at STARVE_MAX.
- It clears on any fetch grant.
- When the count equals STARVE_MAX and both requests are present, fetch wins.
REQ-018 if_rdata and d_rdata hold their last value between rvalid pulses.
REQ-019 Requests that drop before a grant are ignored; no request is queued.

Reset
REQ-020 On rst_n low, immediately and asynchronously:
- State becomes IDLE.
- mem_req, if_gnt, d_gnt, if_rvalid and d_rvalid are 0.
- Registered fields, rdata and the starvation counter are 0.
REQ-021 Reset mid-transaction abandons it; no rvalid is issued after reset release.
REQ-022 The first grant is possible in the first clock cycle after rst_n deasserts.

Configuration
REQ-023 Macro ARB_STARVE_GUARD_EN: when defined, REQ-017 applies; when undefined, there is no counter and data always wins ties (strict priority).

Structure
REQ-024 Shared package arb_pkg holds:
- the state enum (IDLE, BUSY_IF, BUSY_D);
- the owner encoding (OWN_IF, OWN_D);
- the default STARVE_MAX constant;
- the fetch constants MEM_BE_ALL = 4'hF and WE_READ = 0.
REQ-025 The sub-module arb_starve_ctr (saturating counter, clear, increment, at_max flag) is instantiated only under ARB_STARVE_GUARD_EN.

Verification
REQ-026 Single fetch: if_req with if_addr=0x100, mem_ready held 1, mem_rdata=0x00000013:
- if_gnt in cycle 0;
- mem_req with mem_addr=0x100 in cycle 1;
- if_rvalid with if_rdata=0x00000013 in cycle 2;
- fetch_stall=1 in cycles 0-1.
REQ-027 Tie and wait states: if_req and d_req both high, d_we=1, d_addr=0x2000, d_be=4'b0011, d_wdata=0xDEADBEEF, mem_ready low for 3 cycles:
- d_gnt fires first;
- mem_* stay stable for 4 cycles;
- d_rvalid is asserted, then if_gnt follows.
REQ-028 Starvation (ARB_STARVE_GUARD_EN, STARVE_MAX=4): if_req and d_req held high continuously gives exactly 4 d_gnt, then 1 if_gnt, repeating; without the macro, if_gnt never fires.
REQ-029 Flush: if_flush pulses during BUSY_IF with mem_ready=1:
- if_rvalid stays 0;
- the state returns to IDLE;
- the next fetch is granted normally.
REQ-030 Reset mid-op: rst_n driven low in BUSY_D:
- mem_req drops the same cycle, without waiting for a clock edge;
- after release, there is no d_rvalid and the counter reads 0.
